// File: rtl/enc_pkg.sv
// Shared quadrature types and helpers: {A,B} state, step direction,
// Gray-code step decode and a width-parametrised saturating add.
package enc_pkg;

    localparam int SAT_MAX_W = 32;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        CW   = 2'b01,
        CCW  = 2'b11
    } dir_e;

    typedef struct packed {
        logic signed [1:0] delta;
        logic              illegal;
    } step_t;

    // Position of a state along the clockwise cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] gray_pos(input quad_t q);
        case (q)
            2'b00:   return 2'd0;
            2'b10:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // A distance of 2 along the cycle is exactly "both bits flipped".
    function automatic step_t quad_step(input quad_t prev, input quad_t cur);
        step_t      s;
        logic [1:0] diff;
        diff      = gray_pos(cur) - gray_pos(prev);
        s.delta   = NONE;
        s.illegal = 1'b0;
        case (diff)
            2'd1:    s.delta = CW;
            2'd3:    s.delta = CCW;
            2'd2:    s.illegal = 1'b1;
            default: s.delta = NONE;
        endcase
        return s;
    endfunction

    // acc + delta clamped to the signed range of 'width' bits (width <= SAT_MAX_W).
    function automatic logic signed [SAT_MAX_W-1:0] sat_add(
        input logic signed [SAT_MAX_W-1:0] acc,
        input logic signed [1:0]           delta,
        input int                          width
    );
        logic signed [SAT_MAX_W:0] sum;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        logic signed [SAT_MAX_W:0] one;
        one = {{SAT_MAX_W{1'b0}}, 1'b1};
        hi  = (one << (width - 1)) - one;
        lo  = ~hi;
        sum = {acc[SAT_MAX_W-1], acc} + {{(SAT_MAX_W-1){delta[1]}}, delta};
        if (sum > hi) begin
            return hi[SAT_MAX_W-1:0];
        end
        if (sum < lo) begin
            return lo[SAT_MAX_W-1:0];
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/quad_decoder_ch.sv
// One encoder channel: pin synchroniser, priming, 4x decode, wrapping
// position, saturating window accumulator, latched speed and sticky error.
module quad_decoder_ch
    import enc_pkg::*;
#(
    parameter int POS_W       = 32,
    parameter int SPD_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a,
    input  logic                    b,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    input  logic                    win_tc,
    output logic signed [POS_W-1:0] pos,
    output logic signed [SPD_W-1:0] speed,
    output logic                    err
);

    logic [SYNC_STAGES-1:0]        a_sync_reg;
    logic [SYNC_STAGES-1:0]        b_sync_reg;
    logic [SYNC_STAGES:0]          prime_reg;
    quad_t                         prev_reg;
    quad_t                         cur;
    logic signed [POS_W-1:0]       pos_reg, pos_next;
    logic signed [SPD_W-1:0]       acc_reg, acc_next, acc_sum;
    logic signed [SPD_W-1:0]       speed_reg, speed_next;
    logic                          err_reg, err_next;
    step_t                         step;
    logic signed [1:0]             delta;
    logic                          illegal;
    logic signed [SAT_MAX_W-1:0]   sum_wide;
    logic                          sum_unused;

    assign cur        = {a_sync_reg[SYNC_STAGES-1], b_sync_reg[SYNC_STAGES-1]};
    assign sum_unused = ^sum_wide;

    // Decoding waits one cycle beyond the synchroniser depth so that prev
    // already holds a real pin sample rather than the reset zeros.
    always_comb begin
        step    = quad_step(prev_reg, cur);
        delta   = 2'sd0;
        illegal = 1'b0;
        if (prime_reg[SYNC_STAGES]) begin
            delta   = step.delta;
            illegal = step.illegal;
        end
        sum_wide   = sat_add(SAT_MAX_W'(acc_reg), delta, SPD_W);
        acc_sum    = sum_wide[SPD_W-1:0];
        pos_next   = pos_clr ? '0 : pos_reg + POS_W'(delta);
        acc_next   = win_tc ? '0 : acc_sum;
        speed_next = win_tc ? acc_sum : speed_reg;
        err_next   = illegal | (err_reg & ~err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync_reg <= '0;
            b_sync_reg <= '0;
            prime_reg  <= '0;
            prev_reg   <= '0;
            pos_reg    <= '0;
            acc_reg    <= '0;
            speed_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            a_sync_reg <= {a_sync_reg[SYNC_STAGES-2:0], a};
            b_sync_reg <= {b_sync_reg[SYNC_STAGES-2:0], b};
            prime_reg  <= {prime_reg[SYNC_STAGES-1:0], 1'b1};
            prev_reg   <= cur;
            pos_reg    <= pos_next;
            acc_reg    <= acc_next;
            speed_reg  <= speed_next;
            err_reg    <= err_next;
        end
    end

    assign pos   = pos_reg;
    assign speed = speed_reg;
    assign err   = err_reg;

endmodule

// File: rtl/quad_encoder_bank.sv
// Multi-channel quadrature encoder interface: shared sample-window counter
// driving N_CH independent channel decoders.
module quad_encoder_bank
    import enc_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int POS_W       = 32,
    parameter int SPD_W       = 16,
    parameter int WINDOW      = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         a,
    input  logic [N_CH-1:0]         b,
    input  logic [N_CH-1:0]         pos_clr,
    input  logic [N_CH-1:0]         err_clr,
    output logic [N_CH*POS_W-1:0]   pos,
    output logic [N_CH*SPD_W-1:0]   speed,
    output logic                    sample_valid,
    output logic [N_CH-1:0]         err
);

    localparam int CNT_W = $clog2(WINDOW);

    logic [CNT_W-1:0] win_cnt_reg, win_cnt_next;
    logic             win_tc;
    logic             sample_valid_reg;

    assign win_tc       = (win_cnt_reg == CNT_W'(WINDOW - 1));
    assign win_cnt_next = win_tc ? '0 : win_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_reg      <= '0;
            sample_valid_reg <= 1'b0;
        end else begin
            win_cnt_reg      <= win_cnt_next;
            sample_valid_reg <= win_tc;
        end
    end

    assign sample_valid = sample_valid_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            quad_decoder_ch #(
                .POS_W       (POS_W),
                .SPD_W       (SPD_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .a       (a[gi]),
                .b       (b[gi]),
                .pos_clr (pos_clr[gi]),
                .err_clr (err_clr[gi]),
                .win_tc  (win_tc),
                .pos     (pos[gi*POS_W +: POS_W]),
                .speed   (speed[gi*SPD_W +: SPD_W]),
                .err     (err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench: dut_m (WINDOW=100) and dut_w (WINDOW=1000), SPD_W=8, POS_W=16.
module tb_quad_encoder_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_m_n, rst_w_n;
    logic [1:0]  a_m, b_m, pclr_m, eclr_m, err_m;
    logic [1:0]  a_w, b_w, pclr_w, eclr_w, err_w;
    logic [31:0] pos_m, pos_w;
    logic [15:0] spd_m, spd_w;
    logic        sv_m, sv_w;

    int checks = 0;
    int passed = 0;

    logic [1:0] seq [4];
    int idx_m [2];
    int idx_w [2];

    quad_encoder_bank #(.N_CH(2), .POS_W(16), .SPD_W(8), .WINDOW(100), .SYNC_STAGES(2)) dut_m (
        .clk(clk), .reset(rst_m_n), .a(a_m), .b(b_m), .pos_clr(pclr_m), .err_clr(eclr_m),
        .pos(pos_m), .speed(spd_m), .sample_valid(sv_m), .err(err_m)
    );

    quad_encoder_bank #(.N_CH(2), .POS_W(16), .SPD_W(8), .WINDOW(1000), .SYNC_STAGES(2)) dut_w (
        .clk(clk), .reset(rst_w_n), .a(a_w), .b(b_w), .pos_clr(pclr_w), .err_clr(eclr_w),
        .pos(pos_w), .speed(spd_w), .sample_valid(sv_w), .err(err_w)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_m(input int ch, input int dir);
        idx_m[ch] = (idx_m[ch] + dir + 4) % 4;
        a_m[ch] = seq[idx_m[ch]][1];
        b_m[ch] = seq[idx_m[ch]][0];
    endtask

    task automatic step_w(input int ch, input int dir);
        idx_w[ch] = (idx_w[ch] + dir + 4) % 4;
        a_w[ch] = seq[idx_w[ch]][1];
        b_w[ch] = seq[idx_w[ch]][0];
    endtask

    task automatic wait_sv_m(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (sv_m) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_sv_w(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (sv_w) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst_m_n = 1'b0; rst_w_n = 1'b0;
        a_m = 2'b11; b_m = 2'b11; a_w = 2'b11; b_w = 2'b11;
        pclr_m = '0; eclr_m = '0; pclr_w = '0; eclr_w = '0;
        idx_m[0] = 2; idx_m[1] = 2; idx_w[0] = 2; idx_w[1] = 2;
        tick(3);
        checks++; if (pos_m !== 32'h0) $display("FAIL reset_pos actual=%h required=%h", pos_m, 32'h0); else passed++;
        checks++; if (spd_m !== 16'h0) $display("FAIL reset_speed actual=%h required=%h", spd_m, 16'h0); else passed++;
        checks++; if (sv_m !== 1'b0) $display("FAIL reset_sv actual=%b required=0", sv_m); else passed++;
        checks++; if (err_m !== 2'b00) $display("FAIL reset_err actual=%b required=00", err_m); else passed++;
        rst_m_n = 1'b1; rst_w_n = 1'b1;
        wait_sv_m(150, n);
        $display("reset release: first sample_valid after %0d edges", n);
        checks++; if (n !== 100) $display("FAIL first_pulse_cycle actual=%0d required=100", n); else passed++;
        checks++; if (spd_m !== 16'h0) $display("FAIL first_pulse_speed actual=%h required=%h", spd_m, 16'h0); else passed++;
        checks++; if (pos_m !== 32'h0) $display("FAIL prime_pos actual=%h required=%h", pos_m, 32'h0); else passed++;
        checks++; if (err_m !== 2'b00) $display("FAIL prime_err actual=%b required=00", err_m); else passed++;
    endtask

    task automatic test_ccw_ch1;
        int n;
        for (int i = 0; i < 8; i++) begin
            step_m(1, -1);
            tick(4);
        end
        wait_sv_m(100, n);
        $display("ch1 ccw x8: pos1=%h speed1=%h", pos_m[31:16], spd_m[15:8]);
        checks++; if (n !== 68) $display("FAIL ccw_pulse_cycle actual=%0d required=68", n); else passed++;
        checks++; if (spd_m[15:8] !== 8'hF8) $display("FAIL ccw_speed1 actual=%h required=f8", spd_m[15:8]); else passed++;
        checks++; if (pos_m[31:16] !== 16'hFFF8) $display("FAIL ccw_pos1 actual=%h required=fff8", pos_m[31:16]); else passed++;
        checks++; if (spd_m[7:0] !== 8'h00) $display("FAIL ccw_speed0 actual=%h required=00", spd_m[7:0]); else passed++;
        checks++; if (pos_m[15:0] !== 16'h0000) $display("FAIL ccw_pos0 actual=%h required=0000", pos_m[15:0]); else passed++;
        pclr_m[1] = 1'b1;
        tick(1);
        pclr_m[1] = 1'b0;
        $display("ch1 pos_clr: pos1=%h", pos_m[31:16]);
        checks++; if (pos_m[31:16] !== 16'h0000) $display("FAIL pos_clr1 actual=%h required=0000", pos_m[31:16]); else passed++;
    endtask

    task automatic test_illegal;
        step_m(0, 1); tick(4);
        step_m(0, 1); tick(4);
        checks++; if (pos_m[15:0] !== 16'd2) $display("FAIL pre_illegal_pos actual=%0d required=2", pos_m[15:0]); else passed++;
        a_m[0] = 1'b1; b_m[0] = 1'b1; idx_m[0] = 2;
        tick(5);
        $display("illegal 00->11: err=%b pos0=%0d", err_m, pos_m[15:0]);
        checks++; if (err_m[0] !== 1'b1) $display("FAIL illegal_err actual=%b required=1", err_m[0]); else passed++;
        checks++; if (pos_m[15:0] !== 16'd2) $display("FAIL illegal_pos actual=%0d required=2", pos_m[15:0]); else passed++;
        checks++; if (err_m[1] !== 1'b0) $display("FAIL illegal_err1 actual=%b required=0", err_m[1]); else passed++;
        a_m[0] = 1'b0; b_m[0] = 1'b0; idx_m[0] = 0;
        tick(2);
        eclr_m[0] = 1'b1;
        tick(1);
        eclr_m[0] = 1'b0;
        $display("err_clr with illegal 11->00: err=%b", err_m);
        checks++; if (err_m[0] !== 1'b1) $display("FAIL set_wins_err actual=%b required=1", err_m[0]); else passed++;
        checks++; if (pos_m[15:0] !== 16'd2) $display("FAIL set_wins_pos actual=%0d required=2", pos_m[15:0]); else passed++;
        tick(2);
        eclr_m[0] = 1'b1;
        tick(1);
        eclr_m[0] = 1'b0;
        $display("err_clr alone: err=%b", err_m);
        checks++; if (err_m[0] !== 1'b0) $display("FAIL err_clr actual=%b required=0", err_m[0]); else passed++;
    endtask

    task automatic test_boundary;
        int n;
        wait_sv_m(100, n);
        checks++; if (n < 1) $display("FAIL boundary_sync actual=%0d required=1..100", n); else passed++;
        tick(97);
        step_m(0, 1);
        tick(3);
        $display("edge on terminal cycle: sv=%b speed0=%0d pos0=%0d", sv_m, spd_m[7:0], pos_m[15:0]);
        checks++; if (sv_m !== 1'b1) $display("FAIL tc_edge_sv actual=%b required=1", sv_m); else passed++;
        checks++; if (spd_m[7:0] !== 8'd1) $display("FAIL tc_edge_speed actual=%0d required=1", spd_m[7:0]); else passed++;
        checks++; if (pos_m[15:0] !== 16'd3) $display("FAIL tc_edge_pos actual=%0d required=3", pos_m[15:0]); else passed++;
        tick(100);
        $display("next window: sv=%b speed0=%0d", sv_m, spd_m[7:0]);
        checks++; if (sv_m !== 1'b1) $display("FAIL next_window_sv actual=%b required=1", sv_m); else passed++;
        checks++; if (spd_m[7:0] !== 8'd0) $display("FAIL next_window_speed actual=%0d required=0", spd_m[7:0]); else passed++;
    endtask

    task automatic test_mid_reset;
        int n;
        tick(50);
        rst_m_n = 1'b0;
        #2;
        $display("mid-window reset: pos=%h speed=%h sv=%b err=%b", pos_m, spd_m, sv_m, err_m);
        checks++; if (pos_m !== 32'h0) $display("FAIL mid_reset_pos actual=%h required=0", pos_m); else passed++;
        checks++; if (spd_m !== 16'h0) $display("FAIL mid_reset_speed actual=%h required=0", spd_m); else passed++;
        checks++; if (sv_m !== 1'b0) $display("FAIL mid_reset_sv actual=%b required=0", sv_m); else passed++;
        tick(3);
        rst_m_n = 1'b1;
        wait_sv_m(150, n);
        $display("after mid reset: pulse after %0d edges, pos0=%0d", n, pos_m[15:0]);
        checks++; if (n !== 100) $display("FAIL mid_reset_pulse actual=%0d required=100", n); else passed++;
        checks++; if (pos_m !== 32'h0) $display("FAIL rearm_pos actual=%h required=0", pos_m); else passed++;
        checks++; if (err_m !== 2'b00) $display("FAIL rearm_err actual=%b required=00", err_m); else passed++;
    endtask

    task automatic test_cw_ch0;
        int n;
        wait_sv_w(1100, n);
        checks++; if (n < 1) $display("FAIL cw_sync actual=%0d required=1..1100", n); else passed++;
        for (int i = 0; i < 80; i++) begin
            step_w(0, 1);
            tick(4);
        end
        wait_sv_w(1000, n);
        $display("ch0 cw x80: pos0=%0d speed0=%0d pos1=%0d speed1=%0d", pos_w[15:0], spd_w[7:0], pos_w[31:16], spd_w[15:8]);
        checks++; if (n !== 680) $display("FAIL cw_pulse_cycle actual=%0d required=680", n); else passed++;
        checks++; if (spd_w[7:0] !== 8'd80) $display("FAIL cw_speed0 actual=%0d required=80", spd_w[7:0]); else passed++;
        checks++; if (pos_w[15:0] !== 16'd80) $display("FAIL cw_pos0 actual=%0d required=80", pos_w[15:0]); else passed++;
        checks++; if (pos_w[31:16] !== 16'd0) $display("FAIL cw_pos1 actual=%0d required=0", pos_w[31:16]); else passed++;
        checks++; if (spd_w[15:8] !== 8'd0) $display("FAIL cw_speed1 actual=%0d required=0", spd_w[15:8]); else passed++;
    endtask

    task automatic test_saturation;
        int n;
        pclr_w[0] = 1'b1;
        tick(1);
        pclr_w[0] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step_w(0, 1);
            tick(3);
        end
        wait_sv_w(1000, n);
        $display("ch0 cw x200: pos0=%0d speed0=%h err=%b", pos_w[15:0], spd_w[7:0], err_w);
        checks++; if (n !== 399) $display("FAIL sat_pulse_cycle actual=%0d required=399", n); else passed++;
        checks++; if (spd_w[7:0] !== 8'h7F) $display("FAIL sat_speed0 actual=%h required=7f", spd_w[7:0]); else passed++;
        checks++; if (pos_w[15:0] !== 16'd200) $display("FAIL sat_pos0 actual=%0d required=200", pos_w[15:0]); else passed++;
        checks++; if (err_w !== 2'b00) $display("FAIL sat_err actual=%b required=00", err_w); else passed++;
    endtask

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        test_reset();
        test_ccw_ch1();
        test_illegal();
        test_boundary();
        test_mid_reset();
        test_cw_ch0();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
